adder_requester: RTL

Initiator-side controller for the CGRA tile's combinational `half_adder`. It accepts operand pairs on a valid/ready command port and drives the adder's `a`, `b` and `on_off` pins. It waits a configurable settle time for `ack`, captures `{carry_out, c}` as a WIDTH+1-bit sum, and returns it on a valid/ready result port, with a timeout error if `ack` never arrives. It sits between the tile's operand router and the adder instance, and keeps the adder powered only while an operation is in flight.

---
 rtl/adder_requester.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/adder_requester.sv
// Initiator-side controller for the tile's combinational half_adder: accepts operand
// pairs, powers and drives the adder, waits for ack (or times out) and returns the sum.
module adder_requester #(
  parameter int WIDTH   = 16,
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_on_off,
  input  logic [WIDTH-1:0] add_c,
  input  logic             add_carry_out,
  input  logic             add_ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_err,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             on_off_q, on_off_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH:0]   res_sum_q, res_sum_d;
  logic             res_err_q, res_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    on_off_d    = on_off_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_err_d   = res_err_q;

    case (state_q)
      IDLE: begin
        // cmd_ready comes up one edge after reset release
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          add_a_d     = cmd_a;
          add_b_d     = cmd_b;
          on_off_d    = 1'b1;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          state_d     = DRIVE;
        end
      end

      DRIVE: begin
        cmd_ready_d = 1'b0;
        if (cnt_q != TIMEOUT_C) begin
          cnt_d = cnt_q + CW'(1);
        end
        // a late ack still wins over a timeout in the same cycle
        if (cnt_q >= SETTLE_C && add_ack) begin
          res_sum_d   = {add_carry_out, add_c};
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          on_off_d    = 1'b0;
          add_a_d     = '0;
          add_b_d     = '0;
          state_d     = RESP;
        end else if (cnt_q == TIMEOUT_C) begin
          res_sum_d   = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          on_off_d    = 1'b0;
          add_a_d     = '0;
          add_b_d     = '0;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      on_off_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      on_off_q    <= on_off_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_err_q   <= res_err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_on_off = on_off_q;
  assign res_valid  = res_valid_q;
  assign res_sum    = res_sum_q;
  assign res_err    = res_err_q;
  assign busy       = (state_q != IDLE);

endmodule
